huffman_bit_packer: RTL and testbench

//  Downstream stage of the Huffman encoder: consumes its serial code bitstream (bit-valid, data, done)
//  and packs it MSB-first into bytes held in a small first-word-fall-through FIFO for a byte-wide consumer
//  (UART/ILA/memory). Counts encoded bits per frame and flags FIFO overflow.

---
 rtl/huffman_pkg.sv | 24 ++
 rtl/huffman_bit_packer_byte_fifo.sv | 76 +++++++
 rtl/huffman_bit_packer.sv | 162 ++++++++++++++++
 tb/tb_huffman_bit_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit packer: FSM state encoding,
// byte width and a helper that drops one code bit into a byte MSB-first.
package huffman_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit k of a byte (0-based arrival order) lands at position 7-k.
  function automatic logic [BYTE_W-1:0] place_bit(input logic [BYTE_W-1:0] cur,
                                                  input logic [2:0]        idx,
                                                  input logic              b);
    logic [BYTE_W-1:0] res;
    res = cur;
    res[3'd7 - idx] = b;
    return res;
  endfunction

endpackage

// File: rtl/huffman_bit_packer_byte_fifo.sv
// First-word-fall-through byte FIFO. The head byte is kept in a register so
// it stays stable (last head value) while the FIFO is empty.
module byte_fifo
  import huffman_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic [AW:0]       cnt_next;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == {(AW+1){1'b0}});
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    cnt_next = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_next = cnt + CNT_ONE;
      2'b01:   cnt_next = cnt - CNT_ONE;
      default: cnt_next = cnt;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, and the registered head byte / valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {(AW+1){1'b0}};
      dout   <= {BYTE_W{1'b0}};
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      cnt   <= cnt_next;
      valid <= (cnt_next != {(AW+1){1'b0}});
      // New head: incoming byte when it becomes the only entry, otherwise the
      // entry behind the one being popped.
      if (do_push && (empty || (do_pop && (cnt == CNT_ONE)))) begin
        dout <= din;
      end else if (do_pop && (cnt > CNT_ONE)) begin
        dout <= mem[rd_ptr + {{(AW-1){1'b0}}, 1'b1}];
      end
    end
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs the encoder's serial code bits MSB-first into bytes, buffers them in
// a FWFT FIFO, counts bits per frame and flags dropped bytes.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_start,
  input  logic              in_data,
  input  logic              in_done,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_byte,
  input  logic              out_ready,
  output logic              frame_done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  state_t            next_state;
  logic [BYTE_W-1:0] shift_reg;
  logic [BYTE_W-1:0] shift_next;
  logic [BYTE_W-1:0] cur_byte;
  logic [BYTE_W-1:0] push_byte;
  logic [2:0]        bit_idx;
  logic [2:0]        idx_next;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              fd_next;
  logic              accept;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  // Bits are only taken while idle or packing; the encoder leaves a gap after done.
  assign accept   = in_start && ((state == ST_IDLE) || (state == ST_PACK));
  assign cur_byte = place_bit(shift_reg, bit_idx, in_data);
  assign drop     = push && fifo_full && !(out_ready && !fifo_empty);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a bit arriving with done is packed then flushed.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (in_done) begin
          next_state = in_start ? ST_FLUSH : ST_DONE;
        end else if (in_start) begin
          next_state = ST_PACK;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (in_done) begin
          next_state = ST_FLUSH;
        end else begin
          next_state = ST_PACK;
        end
      end
      ST_FLUSH: next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Datapath controls: bit placement, byte push, bit counting, done pulse.
  always_comb begin
    push       = 1'b0;
    push_byte  = shift_reg;
    shift_next = shift_reg;
    idx_next   = bit_idx;
    count_next = bit_count;
    case (state)
      ST_IDLE, ST_PACK: begin
        if (accept) begin
          if (state == ST_IDLE) begin
            count_next = CNT_ONE;
          end else if (bit_count != CNT_MAX) begin
            count_next = bit_count + CNT_ONE;
          end else begin
            count_next = bit_count;
          end
          if (bit_idx == 3'd7) begin
            push       = 1'b1;
            push_byte  = cur_byte;
            shift_next = {BYTE_W{1'b0}};
            idx_next   = 3'd0;
          end else begin
            shift_next = cur_byte;
            idx_next   = bit_idx + 3'd1;
          end
        end else if (in_done && (state == ST_IDLE)) begin
          count_next = {CNT_W{1'b0}};
        end else begin
          count_next = bit_count;
        end
      end
      ST_FLUSH: begin
        push       = (bit_idx != 3'd0);
        push_byte  = shift_reg;
        shift_next = {BYTE_W{1'b0}};
        idx_next   = 3'd0;
      end
      ST_DONE: begin
        shift_next = {BYTE_W{1'b0}};
        idx_next   = 3'd0;
      end
      default: begin
        shift_next = {BYTE_W{1'b0}};
        idx_next   = 3'd0;
      end
    endcase
    fd_next = (next_state == ST_DONE);
  end

  // Shift register, bit index, counter and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= {BYTE_W{1'b0}};
      bit_idx    <= 3'd0;
      bit_count  <= {CNT_W{1'b0}};
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      shift_reg  <= shift_next;
      bit_idx    <= idx_next;
      bit_count  <= count_next;
      frame_done <= fd_next;
      overflow   <= overflow || drop;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_byte),
    .pop   (out_ready),
    .dout  (out_byte),
    .valid (out_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Scoreboard bench for huffman_bit_packer: stimulus tasks derive expected
// bytes from the frame's bit list; a negedge monitor checks every pop.
module tb_huffman_bit_packer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_start = 1'b0;
  logic       in_data = 1'b0;
  logic       in_done = 1'b0;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready = 1'b0;
  logic       frame_done;
  logic [CNT_W-1:0] bit_count;
  logic       overflow;

  huffman_bit_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_data(in_data), .in_done(in_done),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
    .frame_done(frame_done), .bit_count(bit_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  bit frame_bits[$];
  int fd_seen = 0;
  int fd_exp = 0;
  int exp_bc = 0;
  bit drop_next = 1'b0;
  bit rdy_mode = 1'b0;
  bit rdy_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build a byte from 8 frame bits starting at base, first bit in bit 7, zero-padded.
  function automatic logic [7:0] bits_to_byte(input int base);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = v << 1;
      if (base + i < frame_bits.size()) v[0] = frame_bits[base + i];
    end
    return v;
  endfunction

  task automatic model_end_frame();
    if (frame_bits.size() % 8 != 0) sb.push_back(bits_to_byte(frame_bits.size() - frame_bits.size() % 8));
    exp_bc = (frame_bits.size() > 65535) ? 65535 : frame_bits.size();
    fd_exp++;
    frame_bits.delete();
  endtask

  task automatic send_bit(input bit b, input bit done);
    in_start = 1'b1; in_data = b; in_done = done;
    frame_bits.push_back(b);
    if (frame_bits.size() % 8 == 0) begin
      if (drop_next) drop_next = 1'b0;
      else sb.push_back(bits_to_byte(frame_bits.size() - 8));
    end
    if (done) model_end_frame();
    @(posedge clk); #1;
    in_start = 1'b0; in_data = 1'b0; in_done = 1'b0;
  endtask

  task automatic send_done();
    in_done = 1'b1;
    model_end_frame();
    @(posedge clk); #1;
    in_done = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_frame_end(input string tag);
    wait_cycles(3);
    @(negedge clk);
    check({tag, "_frame_done_count"}, fd_seen, fd_exp);
    check({tag, "_bit_count"}, bit_count, exp_bc);
  endtask

  task automatic drain();
    rdy_mode = 1'b0; rdy_force = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_scoreboard_empty", sb.size(), 0);
    check("drain_out_valid_low", out_valid, 1'b0);
    rdy_force = 1'b0;
  endtask

  // Consumer ready: forced value or random backpressure.
  initial forever begin
    @(posedge clk); #2;
    out_ready = rdy_mode ? ($urandom_range(0, 1) == 1) : rdy_force;
  end

  // Monitor: count done pulses and check each popped byte against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (frame_done) fd_seen++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_byte", out_byte, 32'hFFFF_FFFF);
        else check("pop_byte", out_byte, sb.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] pat;
    int len;
    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_bit_count", bit_count, 0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    wait_cycles(2);

    // 0xB2 with latency check
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) send_bit(pat[i], 1'b0);
    @(negedge clk);
    check("b2_latency_valid", out_valid, 1'b1);
    check("b2_latency_byte", out_byte, 8'hB2);
    send_done();
    check_frame_end("b2");
    drain();

    // 11 ones, done with last bit
    for (int i = 0; i < 11; i++) send_bit(1'b1, i == 10);
    check_frame_end("ones11");
    drain();
    wait_cycles(4);
    check("ones11_no_extra", out_valid, 1'b0);

    // done in IDLE
    send_done();
    check_frame_end("empty");
    check("empty_no_byte", out_valid, 1'b0);

    // Fill FIFO, push+pop at full, then a dropped byte
    for (int i = 0; i < 135; i++) send_bit($urandom_range(0, 1), 1'b0);
    rdy_force = 1'b1;
    send_bit($urandom_range(0, 1), 1'b0);
    rdy_force = 1'b0;
    wait_cycles(2);
    check("full_pushpop_no_overflow", overflow, 1'b0);
    for (int i = 0; i < 7; i++) send_bit($urandom_range(0, 1), 1'b0);
    drop_next = 1'b1;
    send_bit($urandom_range(0, 1), 1'b0);
    wait_cycles(1);
    check("overflow_set", overflow, 1'b1);
    send_done();
    check_frame_end("ovf");
    drain();
    check("overflow_sticky", overflow, 1'b1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_byte", out_byte, 8'h00);
    check("midrst_bit_count", bit_count, 0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    frame_bits.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(1);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(pat[i], i == 0);
    check_frame_end("a5");
    drain();

    // Random frames with random backpressure
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 40);
      rdy_mode = 1'b1;
      for (int i = 0; i < len; i++) begin
        bit last;
        last = (i == len - 1) && ($urandom_range(0, 1) == 1);
        send_bit($urandom_range(0, 1), last);
        if (i == len - 1 && !last) send_done();
        else if ($urandom_range(0, 3) == 0 && i != len - 1) wait_cycles($urandom_range(1, 3));
      end
      check_frame_end("rand");
      drain();
    end

    // Bit counter saturation
    rdy_force = 1'b1;
    for (int i = 0; i < 65540; i++) send_bit($urandom_range(0, 1), i == 65539);
    check_frame_end("sat");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
